// File: rtl/apb_ram_pkg.sv
// Shared types and helpers for the APB RAM completer.
package apb_ram_pkg;

    // Largest wait-state count the 4-bit wait counter can hold.
    localparam int unsigned MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } apb_ram_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_ram_ctrl_if.sv
// APB3/APB4 bus bundle between a requester and the RAM completer.
interface apb_ram_ctrl_if #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_W-1:0]       PADDR;
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_ram_array.sv
// Single-port byte-enabled synchronous RAM with registered read (read-first).
module apb_ram_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned IDX_W      = 6
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane writes plus an unconditional registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/apb_ram_ctrl.sv
// Parametrised APB completer RAM: IDLE/WAIT/DONE FSM, wait-state counter,
// range/alignment error decode and PREADY/PSLVERR/PRDATA generation.
// Optional byte strobes: define APB_RAM_CTRL_STRB_EN to honour PSTRB;
// otherwise every write updates the full word.
module apb_ram_ctrl
    import apb_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic           PCLK,
    input logic           PRESETn,
    apb_ram_ctrl_if.slave bus
);
    localparam int unsigned NB       = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = clog2_f(NB);
    localparam int unsigned IDX_W    = clog2_f(DEPTH);
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((64'd1 << ADDR_LSB) - 64'd1);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    apb_ram_state_e        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  rd_done_q, rd_done_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  misaligned;
    logic                  out_of_range;
    logic                  enter_done;
    logic                  ram_we;
    logic [NB-1:0]         ram_be;
    logic [IDX_W-1:0]      ram_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Access error decode on the live address; latched when leaving IDLE.
    always_comb begin
        misaligned   = (bus.PADDR & LSB_MASK) != '0;
        out_of_range = (64'(bus.PADDR) >> ADDR_LSB) >= 64'(DEPTH);
    end

    assign ram_idx = bus.PADDR[ADDR_LSB +: IDX_W];

`ifdef APB_RAM_CTRL_STRB_EN
    assign ram_be = bus.PSTRB;
`else
    logic unused_strb;
    assign ram_be      = '1;
    assign unused_strb = ^bus.PSTRB;
`endif

    // Next-state, wait counter and commit strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        enter_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.PSEL && bus.PENABLE) begin
                    cnt_d = WAIT_INIT;
                    err_d = misaligned || out_of_range;
                    if (WAIT_INIT == 4'd0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.PSEL) begin
                    // Requester abandoned the transfer: nothing is committed.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response flags for the DONE cycle, derived at the commit edge.
    always_comb begin
        ram_we    = enter_done && bus.PWRITE && !err_d;
        pready_d  = enter_done;
        pslverr_d = enter_done && err_d;
        rd_done_d = enter_done && !bus.PWRITE && !err_d;
    end

    // Read data: the RAM output register is valid in DONE; otherwise hold.
    always_comb begin
        prdata_d = prdata_q;
        if (rd_done_q) begin
            prdata_d = ram_rdata;
        end else if (pslverr_q) begin
            prdata_d = '0;
        end
    end

    // Control and response registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            rd_done_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            rd_done_q <= rd_done_d;
            prdata_q  <= prdata_d;
        end
    end

    assign bus.PRDATA  = prdata_d;
    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;

    apb_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (PCLK),
        .we    (ram_we),
        .be    (ram_be),
        .idx   (ram_idx),
        .wdata (bus.PWDATA),
        .rdata (ram_rdata)
    );

endmodule
